// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver.
// State encoding and don't-care policy selectors.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int unsigned DC_ZERO = 0;
    localparam int unsigned DC_ONE  = 1;

    function automatic logic dc_level(input int unsigned policy);
        return (policy == DC_ONE);
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation for a vector of lanes.
// Don't-care terms resolve to a fixed level set by DC_POLICY.
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned N         = 1,
    parameter int unsigned DC_POLICY = DC_ZERO
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] t,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    logic [N-1:0] dc;

    always_comb begin
        dc = {N{dc_level(DC_POLICY)}};
        // From Q=0 only J matters; from Q=1 only K matters.
        j  = (~q & t) | (q & dc);
        k  = (q & ~t) | (~q & dc);
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of external JK flops toward a target word for one cycle,
// then checks the returned Q and tracks mismatches.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int unsigned N         = 1,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DC_POLICY = DC_ZERO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [N-1:0]     tgt_data,
    input  logic [N-1:0]     q_in,
    output logic [N-1:0]     j,
    output logic [N-1:0]     k,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt
);

    state_e           state_q, state_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [N-1:0]     j_q, j_d;
    logic [N-1:0]     k_q, k_d;
    logic             done_q, done_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [N-1:0]     exc_j;
    logic [N-1:0]     exc_k;
    logic             mismatch;

    jk_excite #(
        .N         (N),
        .DC_POLICY (DC_POLICY)
    ) u_excite (
        .q (q_in),
        .t (tgt_data),
        .j (exc_j),
        .k (exc_k)
    );

    assign mismatch = |(q_in ^ tgt_q);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        j_d        = j_q;
        k_d        = k_q;
        done_d     = 1'b0;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                j_d     = '0;
                k_d     = '0;
                state_d = CHECK;
            end
            CHECK: begin
                j_d     = '0;
                k_d     = '0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (mismatch) begin
                    err_flag_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;

endmodule
